// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad link (responder and nes_bridge).
package joypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ACK,
    ST_DATA,
    ST_WAIT
  } joypad_state_e;

  localparam logic [7:0] JOYPAD_READ_CMD  = 8'h01;
  localparam int         JOYPAD_DATA_BITS = 32;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a single asynchronous line; reset value selectable
// so idle-high lines do not show a false edge when reset is released.
module synchronizer #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/joypad_responder.sv
// Device end of the two-wire joypad link: decodes start/command, acks a read
// and shifts out a frozen 32-bit pad snapshot. Optional: JOYPAD_RESP_GLITCH_FILTER_EN.
module joypad_responder
  import joypad_pkg::*;
#(
  parameter logic [7:0] READ_CMD = JOYPAD_READ_CMD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_out,
  input  logic [JOYPAD_DATA_BITS-1:0] pad_buttons,
  output logic                        busy,
  output logic                        served
);

  logic w_scl_sync, w_sda_sync;
  logic w_scl, w_sda;

  synchronizer #(.RST_VAL(1'b1)) u_sync_scl (
    .clk (clk),
    .rst (rst),
    .i_d (scl_in),
    .o_q (w_scl_sync)
  );

  synchronizer #(.RST_VAL(1'b1)) u_sync_sda (
    .clk (clk),
    .rst (rst),
    .i_d (sda_in),
    .o_q (w_sda_sync)
  );

`ifdef JOYPAD_RESP_GLITCH_FILTER_EN
  // Majority over three history samples: a single-cycle pulse never wins.
  logic [2:0] r_scl_hist, r_sda_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_hist <= '1;
      r_sda_hist <= '1;
    end else begin
      r_scl_hist <= {r_scl_hist[1:0], w_scl_sync};
      r_sda_hist <= {r_sda_hist[1:0], w_sda_sync};
    end
  end

  assign w_scl = maj3(r_scl_hist);
  assign w_sda = maj3(r_sda_hist);
`else
  assign w_scl = w_scl_sync;
  assign w_sda = w_sda_sync;
`endif

  logic r_scl_q, r_sda_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign w_scl_rise = w_scl & ~r_scl_q;
  assign w_scl_fall = ~w_scl & r_scl_q;
  assign w_start    = w_scl & r_scl_q & r_sda_q & ~w_sda;
  assign w_stop     = w_scl & r_scl_q & ~r_sda_q & w_sda;

  joypad_state_e               r_state, w_state_nxt;
  logic [5:0]                  r_cnt, w_cnt_nxt;
  logic [7:0]                  r_cmd, w_cmd_nxt;
  logic                        r_match, w_match_nxt;
  logic [JOYPAD_DATA_BITS-1:0] r_snap, w_snap_nxt;
  logic                        r_sda, w_sda_nxt;
  logic                        r_served, w_served_nxt;
  logic [7:0]                  w_cmd_shift;
  logic [4:0]                  w_bit_idx;

  assign w_cmd_shift = {r_cmd[6:0], w_sda};
  assign w_bit_idx   = 5'(JOYPAD_DATA_BITS - 1) - r_cnt[4:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cmd    <= '0;
      r_match  <= 1'b0;
      r_snap   <= '0;
      r_sda    <= 1'b1;
      r_served <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cmd    <= w_cmd_nxt;
      r_match  <= w_match_nxt;
      r_snap   <= w_snap_nxt;
      r_sda    <= w_sda_nxt;
      r_served <= w_served_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cmd_nxt    = r_cmd;
    w_match_nxt  = r_match;
    w_snap_nxt   = r_snap;
    w_sda_nxt    = r_sda;
    w_served_nxt = 1'b0;

    // Link conditions override whatever the state machine is doing.
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_sda_nxt   = 1'b1;
    end else if (w_start) begin
      w_state_nxt = ST_CMD;
      w_cnt_nxt   = '0;
      w_sda_nxt   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_sda_nxt = 1'b1;
        ST_CMD: begin
          if (w_scl_rise) begin
            w_cmd_nxt = w_cmd_shift;
            w_cnt_nxt = r_cnt + 6'd1;
            if (r_cnt == 6'd7) begin
              w_match_nxt = (w_cmd_shift == READ_CMD);
              w_snap_nxt  = pad_buttons;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (w_scl_fall) begin
            if (r_match) begin
              w_sda_nxt   = 1'b0;
              w_state_nxt = ST_DATA;
            end else begin
              w_sda_nxt   = 1'b1;
              w_state_nxt = ST_WAIT;
            end
          end
        end
        ST_DATA: begin
          if (w_scl_fall) begin
            if (r_cnt == 6'(JOYPAD_DATA_BITS)) begin
              w_sda_nxt    = 1'b1;
              w_served_nxt = 1'b1;
              w_state_nxt  = ST_WAIT;
            end else begin
              w_sda_nxt = r_snap[w_bit_idx];
              w_cnt_nxt = r_cnt + 6'd1;
            end
          end
        end
        ST_WAIT: w_sda_nxt = 1'b1;
        default: begin
          w_state_nxt = ST_IDLE;
          w_sda_nxt   = 1'b1;
        end
      endcase
    end
  end

  assign sda_out = r_sda;
  assign busy    = (r_state != ST_IDLE);
  assign served  = r_served;

endmodule

// File: tb/tb_joypad_responder.sv
// Bench for joypad_responder: acts as the bridge, checks sda_out/busy every
// cycle of each scl-high window against a transaction-level model.
module tb_joypad_responder;

  localparam int HALF = 10;
`ifdef JOYPAD_RESP_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_in;
  logic        sda_in;
  logic        sda_out;
  logic [31:0] pad_buttons;
  logic        busy;
  logic        served;

  int total = 0;
  int bad   = 0;

  joypad_responder dut (
    .clk         (clk),
    .rst         (rst),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .sda_out     (sda_out),
    .pad_buttons (pad_buttons),
    .busy        (busy),
    .served      (served)
  );

  always #5 clk = ~clk;

  // Transaction model: rise index since start, captured command and snapshot.
  bit          m_active = 1'b0;
  int          m_rise   = 0;
  logic [7:0]  m_cmd    = '0;
  logic [31:0] m_snap   = '0;
  int          exp_served    = 0;
  int          served_cycles = 0;

  bit   chk_en  = 1'b0;
  logic exp_sda = 1'b1;
  logic exp_busy = 1'b0;

  // What the responder presents while scl is high after rise r of a transaction.
  function automatic logic model_sda(input int r, input logic [7:0] cmd,
                                     input logic [31:0] snap, input bit act);
    if (!act || r <= 8) return 1'b1;
    if (cmd != 8'h01) return 1'b1;
    if (r == 9) return 1'b0;
    if (r <= 41) return snap[41 - r];
    return 1'b1;
  endfunction

  always @(posedge clk) if (served === 1'b1) served_cycles++;

  always @(negedge clk) begin
    if (chk_en) begin
      total += 2;
      if (sda_out !== exp_sda) begin
        bad++;
        $display("FAIL sda_out rise=%0d got=%b want=%b t=%0t", m_rise, sda_out, exp_sda, $time);
      end
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy rise=%0d got=%b want=%b t=%0t", m_rise, busy, exp_busy, $time);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic rise_phase(output logic rx);
    scl_in = 1'b1;
    if (m_active) begin
      m_rise++;
      if (m_rise <= 8) m_cmd = {m_cmd[6:0], sda_in};
      if (m_rise == 8) m_snap = pad_buttons;
    end
    wclk(2);
    exp_sda  = model_sda(m_rise, m_cmd, m_snap, m_active);
    exp_busy = m_active;
    chk_en   = 1'b1;
    wclk(HALF - 4);
    rx     = sda_out;
    chk_en = 1'b0;
    wclk(2);
  endtask

  task automatic fall_edge();
    scl_in = 1'b0;
    if (m_active && m_rise == 41 && m_cmd == 8'h01) exp_served++;
  endtask

  task automatic clock_bit(input logic tx, output logic rx);
    wclk(HALF / 2);
    sda_in = tx;
    wclk(HALF / 2);
    rise_phase(rx);
    fall_edge();
  endtask

  task automatic start_cond();
    logic d;
    if (scl_in == 1'b0) begin
      wclk(HALF / 2);
      sda_in = 1'b1;
      wclk(HALF / 2);
      rise_phase(d);
    end
    sda_in   = 1'b0;
    m_active = 1'b1;
    m_rise   = 0;
    m_cmd    = '0;
    wclk(HALF);
    scl_in = 1'b0;
  endtask

  task automatic stop_cond();
    logic d;
    wclk(HALF / 2);
    sda_in = 1'b0;
    wclk(HALF / 2);
    rise_phase(d);
    sda_in   = 1'b1;
    m_active = 1'b0;
    wclk(LAT + 1);
    exp_sda  = 1'b1;
    exp_busy = 1'b0;
    chk_en   = 1'b1;
    wclk(3);
    chk_en = 1'b0;
    check("served_count", served_cycles, exp_served);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], d);
  endtask

  task automatic read_bits(input int n, output logic [31:0] w);
    logic rx;
    w = '0;
    for (int i = 0; i < n; i++) begin
      clock_bit(1'b1, rx);
      w = {w[30:0], rx};
    end
  endtask

  logic        ack;
  logic [31:0] word;

  initial begin
    rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1; pad_buttons = '0;
    wclk(3);
    check("reset_sda_out", 32'(sda_out), 32'h1);
    check("reset_busy",    32'(busy),    32'h0);
    check("reset_served",  32'(served),  32'h0);
    rst = 1'b0;
    wclk(5);

    // Plain read.
    pad_buttons = 32'hA55A_0FF0;
    start_cond();
    send_byte(8'h01);
    clock_bit(1'b1, ack);
    check("read_ack", 32'(ack), 32'h0);
    read_bits(32, word);
    check("read_word", word, 32'hA55A_0FF0);
    stop_cond();
    check("read_served_once", served_cycles, 32'd1);
    check("read_busy_idle", 32'(busy), 32'h0);

    // Non-read command: never acked, line stays high.
    start_cond();
    send_byte(8'h7E);
    clock_bit(1'b1, ack);
    check("badcmd_ack", 32'(ack), 32'h1);
    read_bits(32, word);
    check("badcmd_word", word, 32'hFFFF_FFFF);
    stop_cond();
    check("badcmd_no_served", served_cycles, 32'd1);

    // Snapshot frozen after the 8th rise.
    pad_buttons = 32'h1234_5678;
    start_cond();
    send_byte(8'h01);
    pad_buttons = 32'hFFFF_FFFF;
    clock_bit(1'b1, ack);
    read_bits(32, word);
    check("freeze_word", word, 32'h1234_5678);
    stop_cond();

    // Early stop after 10 data bits, then a full read.
    pad_buttons = 32'h0F0F_1234;
    start_cond();
    send_byte(8'h01);
    clock_bit(1'b1, ack);
    read_bits(10, word);
    stop_cond();
    check("early_stop_no_served", served_cycles, 32'd2);
    start_cond();
    send_byte(8'h01);
    clock_bit(1'b1, ack);
    read_bits(32, word);
    check("after_stop_word", word, 32'h0F0F_1234);
    stop_cond();

    // Repeated start mid-DATA, then a fresh read.
    start_cond();
    send_byte(8'h01);
    clock_bit(1'b1, ack);
    read_bits(5, word);
    pad_buttons = 32'hCAFE_BABE;
    start_cond();
    send_byte(8'h01);
    clock_bit(1'b1, ack);
    check("rstart_ack", 32'(ack), 32'h0);
    read_bits(32, word);
    check("rstart_word", word, 32'hCAFE_BABE);
    stop_cond();

    // Reset in DATA while bit 30 (a zero) is on the line.
    pad_buttons = 32'hA55A_0FF0;
    start_cond();
    send_byte(8'h01);
    clock_bit(1'b1, ack);
    read_bits(1, word);
    wclk(HALF);
    scl_in = 1'b1;
    wclk(4);
    check("pre_reset_sda_low", 32'(sda_out), 32'h0);
    rst = 1'b1;
    #1;
    check("reset_mid_sda", 32'(sda_out), 32'h1);
    check("reset_mid_busy", 32'(busy), 32'h0);
    sda_in   = 1'b1;
    m_active = 1'b0;
    wclk(3);
    rst = 1'b0;
    wclk(LAT + 2);

`ifdef JOYPAD_RESP_GLITCH_FILTER_EN
    // A one-cycle low pulse on scl must not count as an edge.
    pad_buttons = 32'h5A5A_F00F;
    start_cond();
    for (int i = 0; i < 3; i++) clock_bit(1'b0, ack);
    wclk(HALF / 2);
    sda_in = 1'b0;
    wclk(HALF / 2);
    rise_phase(ack);
    scl_in = 1'b0;
    wclk(1);
    scl_in = 1'b1;
    wclk(4);
    fall_edge();
    for (int i = 0; i < 3; i++) clock_bit(1'b0, ack);
    clock_bit(1'b1, ack);
    clock_bit(1'b1, ack);
    check("glitch_ack", 32'(ack), 32'h0);
    read_bits(32, word);
    check("glitch_word", word, 32'h5A5A_F00F);
    stop_cond();
`endif

    // Randomized transactions checked by the model.
    for (int it = 0; it < 14; it++) begin
      logic [7:0] cmd;
      int         n;
      if (!m_active) begin
        pad_buttons = $urandom;
        start_cond();
      end
      cmd = ($urandom_range(0, 3) != 0) ? 8'h01 : 8'($urandom);
      send_byte(cmd);
      pad_buttons = $urandom;
      n = $urandom_range(1, 33);
      read_bits((n > 32) ? 32 : n, word);
      if (n > 32) read_bits(1, word);
      if (it < 13 && $urandom_range(0, 2) == 0) begin
        pad_buttons = $urandom;
        start_cond();
      end else begin
        stop_cond();
      end
    end

    wclk(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
